ssa_csr_bank: RTL and testbench
===============================

// Module: ssa_csr_bank
// PURPOSE
//  Parametrised CSR bank and read arbiter for the spread-spectrum analyzer. Decodes CPU accesses at BASE,
//  holds run, sample-count, limit and IRQ state, and latches per-channel correlation-seen as sticky W1C bits.
//  Channel result reads are fetched from the correlator array over a req/ack handshake with a timeout.
//  Sits between the CPU bus and the NCHAN correlator channels.
// PARAMETERS
//  NCHAN     32            correlator channels, 1..DW
//  DW        32            data width
//  AW        32            address width
//  BASE      32'hfe00_0000 block base address
//  NMIRROR   3             channel windows at BASE+0x200+m*0x200, m=0..NMIRROR-1; requires NCHAN*16 <= 0x200
//  TIMEOUT   16            maximum cycles to wait for ch_ack, >=1
//  ERR_WORD  32'hdead_beef rdata returned when a channel read times out
// PORTS
//  clk       in   1          clock
//  rst       in   1          asynchronous, active-low reset
//  addr      in   AW         byte address
//  wdata     in   DW         write data
//  write     in   1          write strobe, one cycle
//  read      in   1          read strobe, one cycle; accepted only when busy=0
//  busy      out  1          read in flight; master holds off further reads
//  rdata     out  DW         read data, valid when rvalid=1, otherwise 0
//  rvalid    out  1          one-cycle read response
//  push_adc  in   1          ADC sample strobe
//  cseen_in  in   NCHAN      per-channel correlation-seen pulses
//  run       out  1          |GLOBAL_RUN
//  ch_req    out  1          channel fetch request, held until ch_ack or timeout
//  ch_sel    out  log2(NCHAN) channel index
//  ch_word   out  2          addr[3:2] of the access
//  ch_ack    in   1          channel data valid
//  ch_rdata  in   DW         channel data
//  irq       out  1          registered interrupt
// BEHAVIOUR
//  Reset: all registers 0; FSM to IDLE; ch_req, rvalid, busy, irq and rdata go to 0 immediately.
//  Register map (offset from BASE):
//   0x100 GLOBAL_RUN, RW
//   0x104 SAMPLE_COUNT, RW
//   0x108 CSEEN, RO sticky, W1C
//   0x10C STATUS: bit0 done, bit1 timeout_err; both W1C
//   0x110 SAMPLE_LIMIT, RW
//   0x114 IRQ_CTRL: bit0 done_en, bit1 err_en
//   0x118 CSEEN_IRQ_EN, NCHAN bits
//  Unmapped offsets: reads return 0, writes are ignored.
//  SAMPLE_COUNT: a CPU write has priority over increment. Otherwise count +1 on push_adc when run=1.
//   The count saturates at all-ones.
//  Limit: if LIMIT!=0 and an increment makes count==LIMIT, then in the same edge GLOBAL_RUN<=0 and done<=1.
//   A CPU write to GLOBAL_RUN in the same cycle is overridden by the auto-stop.
//  CSEEN: next = (cur & ~w1c_mask) | cseen_in. A set wins over a clear in the same cycle.
//  irq: registered |(CSEEN & CSEEN_IRQ_EN) | (done & done_en) | (err & err_en); one cycle latency.
//  A write accepted in any state takes effect at the next edge. A write never asserts busy.
//  Read FSM:
//   IDLE: read=1 at a CSR offset -> RESP. read=1 in a channel window -> FETCH. Otherwise -> IDLE.
//    ch_sel = ((off-0x200) mod 0x200)>>4. Offsets with ch_sel>=NCHAN are unmapped and -> RESP with 0.
//   RESP: rvalid=1 for one cycle, rdata = register value sampled at the read edge -> IDLE.
//    CSR read latency is 1 cycle.
//   FETCH: ch_req=1 with ch_sel/ch_word held stable.
//    ch_ack=1 -> capture ch_rdata, -> RESP (rvalid is the cycle after ack).
//    TIMEOUT cycles without ack -> rdata=ERR_WORD, err<=1, -> RESP.
//    ch_ack outside FETCH is ignored.
//   busy=1 in FETCH and RESP. A read while busy=1 is dropped.
//  Same-cycle read and write to the same CSR: the read returns the pre-write value.
// TESTING
//  Reset, write 0x104=5, run=1, 3 push_adc -> read 0x104 returns 8, rvalid exactly 1 cycle after read.
//  LIMIT=10, COUNT=8, run=1, 2 pushes -> COUNT=10, GLOBAL_RUN=0, STATUS=1; with done_en=1, irq=1 next cycle.
//  cseen_in[3] pulse, then W1C 0x108=0x8 together with a new cseen_in[3] -> bit3 stays 1; a later W1C clears it.
//  Read BASE+0x4A4 -> ch_sel=10, ch_word=1; ch_ack after 4 cycles with 0x1234 -> rdata=0x1234.
//  Channel read with ch_ack tied 0 -> after 16 cycles ch_req drops, rdata=0xdead_beef, STATUS[1]=1.
//  Assert rst low mid-FETCH -> ch_req/busy low immediately; after release a new CSR read completes normally.

Source files
------------

// File: rtl/ssa_csr_bank.sv
`default_nettype none
//==============================================================================
// ssa_csr_bank
// CSR bank, sticky correlation-seen latches and timed channel-read arbiter
// for the spread-spectrum analyzer.
// Revision: 1.0
//==============================================================================
module ssa_csr_bank #(
    parameter int            NCHAN    = 32,
    parameter int            DW       = 32,
    parameter int            AW       = 32,
    parameter logic [AW-1:0] BASE     = 32'hfe00_0000,
    parameter int            NMIRROR  = 3,
    parameter int            TIMEOUT  = 16,
    parameter logic [DW-1:0] ERR_WORD = 32'hdead_beef,
    localparam int           SELW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    input  logic             write,
    input  logic             read,
    output logic             busy,
    output logic [DW-1:0]    rdata,
    output logic             rvalid,
    input  logic             push_adc,
    input  logic [NCHAN-1:0] cseen_in,
    output logic             run,
    output logic             ch_req,
    output logic [SELW-1:0]  ch_sel,
    output logic [1:0]       ch_word,
    input  logic             ch_ack,
    input  logic [DW-1:0]    ch_rdata,
    output logic             irq
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] CSR_END  = AW'(32'h200);
    localparam logic [AW-1:0] BLK_END  = AW'((NMIRROR + 1) * 32'h200);
    localparam logic [8:0]    OFF_RUN  = 9'h100;
    localparam logic [8:0]    OFF_CNT  = 9'h104;
    localparam logic [8:0]    OFF_CSN  = 9'h108;
    localparam logic [8:0]    OFF_STAT = 9'h10C;
    localparam logic [8:0]    OFF_LIM  = 9'h110;
    localparam logic [8:0]    OFF_ICTL = 9'h114;
    localparam logic [8:0]    OFF_CIEN = 9'h118;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [1:0]        word_q, word_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [DW-1:0]     run_q, run_d;
    logic [DW-1:0]     count_q, count_d;
    logic [DW-1:0]     limit_q, limit_d;
    logic [NCHAN-1:0]  cseen_q, cseen_d;
    logic [NCHAN-1:0]  cien_q, cien_d;
    logic [1:0]        ictl_q, ictl_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;
    logic              err_set, done_set;

    logic [AW-1:0]     off;
    logic [8:0]        roff;
    logic              in_blk, is_csr, is_chan, chan_ok;
    logic              wr_csr;
    logic [DW-1:0]     csr_rval;

    // Mirrored channel windows all alias onto off[8:0] because each is 0x200 wide.
    assign off     = addr - BASE;
    assign roff    = off[8:0];
    assign in_blk  = (addr >= BASE) && (off < BLK_END);
    assign is_csr  = in_blk && (off < CSR_END);
    assign is_chan = in_blk && !is_csr;
    assign chan_ok = is_chan && (32'(off[8:4]) < 32'(NCHAN));
    assign wr_csr  = write && is_csr;

    always_comb begin
        csr_rval = '0;
        if (is_csr) begin
            case (roff)
                OFF_RUN:  csr_rval = run_q;
                OFF_CNT:  csr_rval = count_q;
                OFF_CSN:  csr_rval = DW'(cseen_q);
                OFF_STAT: csr_rval = DW'({err_q, done_q});
                OFF_LIM:  csr_rval = limit_q;
                OFF_ICTL: csr_rval = DW'(ictl_q);
                OFF_CIEN: csr_rval = DW'(cien_q);
                default:  csr_rval = '0;
            endcase
        end
    end

    // Read FSM
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        word_d  = word_q;
        tcnt_d  = tcnt_q;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read && chan_ok) begin
                    state_d = ST_FETCH;
                    sel_d   = off[4 +: SELW];
                    word_d  = addr[3:2];
                    tcnt_d  = '0;
                end else if (read && in_blk) begin
                    state_d = ST_RESP;
                    rdata_d = csr_rval;
                end
            end
            ST_FETCH: begin
                if (ch_ack) begin
                    state_d = ST_RESP;
                    rdata_d = ch_rdata;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                    rdata_d = ERR_WORD;
                    err_set = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CSR next state
    always_comb begin
        run_d    = run_q;
        count_d  = count_q;
        limit_d  = limit_q;
        ictl_d   = ictl_q;
        cien_d   = cien_q;
        done_set = 1'b0;
        if (wr_csr && roff == OFF_RUN)  run_d   = wdata;
        if (wr_csr && roff == OFF_LIM)  limit_d = wdata;
        if (wr_csr && roff == OFF_ICTL) ictl_d  = wdata[1:0];
        if (wr_csr && roff == OFF_CIEN) cien_d  = wdata[NCHAN-1:0];
        if (wr_csr && roff == OFF_CNT) begin
            count_d = wdata;
        end else if (push_adc && run && count_q != '1) begin
            count_d = count_q + DW'(1);
            // Auto-stop overrides any same-cycle CPU write to GLOBAL_RUN.
            if (limit_q != '0 && count_d == limit_q) begin
                run_d    = '0;
                done_set = 1'b1;
            end
        end
        cseen_d = (cseen_q & ~((wr_csr && roff == OFF_CSN) ? wdata[NCHAN-1:0] : '0)) | cseen_in;
        done_d  = (done_q & ~(wr_csr && roff == OFF_STAT && wdata[0])) | done_set;
        err_d   = (err_q  & ~(wr_csr && roff == OFF_STAT && wdata[1])) | err_set;
        irq_d   = (|(cseen_q & cien_q)) | (done_q & ictl_q[0]) | (err_q & ictl_q[1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            sel_q   <= '0;
            word_q  <= '0;
            tcnt_q  <= '0;
            run_q   <= '0;
            count_q <= '0;
            limit_q <= '0;
            cseen_q <= '0;
            cien_q  <= '0;
            ictl_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            tcnt_q  <= tcnt_d;
            run_q   <= run_d;
            count_q <= count_d;
            limit_q <= limit_d;
            cseen_q <= cseen_d;
            cien_q  <= cien_d;
            ictl_q  <= ictl_d;
            done_q  <= done_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign rvalid  = (state_q == ST_RESP);
    assign rdata   = rvalid ? rdata_q : '0;
    assign ch_req  = (state_q == ST_FETCH);
    assign ch_sel  = sel_q;
    assign ch_word = word_q;
    assign run     = |run_q;
    assign irq     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_ssa_csr_bank.sv
`default_nettype none
//==============================================================================
// tb_ssa_csr_bank
// Randomized self-checking bench for ssa_csr_bank against a register-array model.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
module tb_ssa_csr_bank;

    localparam int          NCHAN    = 32;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] BASE     = 32'hfe00_0000;
    localparam logic [31:0] ERR_WORD = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata, ch_rdata = '0;
    logic        write = 1'b0, read = 1'b0, push_adc = 1'b0, ch_ack = 1'b0;
    logic [31:0] cseen_in = '0;
    logic        busy, rvalid, run, ch_req, irq;
    logic [4:0]  ch_sel;
    logic [1:0]  ch_word;

    always #5 clk = ~clk;

    ssa_csr_bank #(
        .NCHAN(NCHAN), .DW(32), .AW(32), .BASE(BASE), .NMIRROR(3),
        .TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .write(write), .read(read),
        .busy(busy), .rdata(rdata), .rvalid(rvalid), .push_adc(push_adc),
        .cseen_in(cseen_in), .run(run), .ch_req(ch_req), .ch_sel(ch_sel),
        .ch_word(ch_word), .ch_ack(ch_ack), .ch_rdata(ch_rdata), .irq(irq)
    );

    // Model: mr[i] is the register at BASE+0x100+4*i
    logic [31:0] mr [7];
    logic        m_irq;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int csr_idx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (o >= 32'h100 && o <= 32'h118 && o[1:0] == 2'b00) return int'((o - 32'h100) >> 2);
        return -1;
    endfunction

    function automatic logic [31:0] mval(input int idx);
        if (idx < 0 || idx > 6) return '0;
        return mr[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 7; i++) mr[i] = '0;
        m_irq = 1'b0;
    endtask

    // One clock: drive inputs, advance the model over the edge, check run/irq.
    task automatic cycle(input logic w, input logic r, input logic [31:0] a, input logic [31:0] wd,
                         input logic ack, input logic [31:0] ad, input logic push,
                         input logic [31:0] cin, input logic errset);
        logic [31:0] old [7];
        int wi;
        write = w; read = r; addr = a; wdata = wd; ch_ack = ack; ch_rdata = ad;
        push_adc = push; cseen_in = cin;
        @(posedge clk);
        for (int i = 0; i < 7; i++) old[i] = mr[i];
        wi = w ? csr_idx(a) : -1;
        case (wi)
            0: mr[0] = wd;
            1: mr[1] = wd;
            2: mr[2] = old[2] & ~wd;
            3: mr[3] = old[3] & ~(wd & 32'h3);
            4: mr[4] = wd;
            5: mr[5] = wd & 32'h3;
            6: mr[6] = wd;
            default: ;
        endcase
        mr[2] = mr[2] | cin;
        if (wi != 1 && push && old[0] != 0 && old[1] != 32'hffff_ffff) begin
            mr[1] = old[1] + 1;
            if (old[4] != 0 && mr[1] == old[4]) begin
                mr[0] = '0;
                mr[3] = mr[3] | 32'h1;
            end
        end
        if (errset) mr[3] = mr[3] | 32'h2;
        m_irq = ((old[2] & old[6]) != 0) || (old[3][0] && old[5][0]) || (old[3][1] && old[5][1]);
        #1;
        write = 1'b0; read = 1'b0; push_adc = 1'b0; cseen_in = '0; ch_ack = 1'b0;
        check("run", 32'(run), 32'(mr[0] != 0));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    function automatic logic rpush();
        return ($urandom % 3) == 0;
    endfunction

    function automatic logic [31:0] rcin();
        return (($urandom % 4) == 0) ? (32'h1 << ($urandom % 32)) : 32'h0;
    endfunction

    task automatic pick_wr(output logic [31:0] a, output logic [31:0] d);
        int idx;
        idx = int'($urandom % 8);
        a = BASE + 32'h100 + 32'(idx) * 4;
        case (idx)
            0: d = $urandom % 4;
            1: d = $urandom % 24;
            4: d = $urandom % 30;
            default: d = $urandom;
        endcase
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cycle(1'b1, 1'b0, BASE + off, d, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic csr_read(input logic [31:0] a, input logic w, input logic [31:0] wd);
        logic [31:0] exp;
        logic [31:0] da, dd;
        exp = mval(csr_idx(a));
        cycle(w, 1'b1, a, wd, 1'($urandom), $urandom, rpush(), rcin(), 1'b0);
        check("csr_rvalid", 32'(rvalid), 32'd1);
        check("csr_rdata", rdata, exp);
        check("csr_busy", 32'(busy), 32'd1);
        pick_wr(da, dd);
        cycle(1'b0, 1'b1, da, '0, 1'($urandom), $urandom, rpush(), rcin(), 1'b0);
        check("resp_end_rvalid", 32'(rvalid), 32'd0);
        check("resp_end_busy", 32'(busy), 32'd0);
        check("idle_rdata", rdata, 32'd0);
    endtask

    task automatic chan_read(input int ch, input int word, input int mir, input int delay,
                             input logic [31:0] data);
        logic [31:0] a, wa, wd;
        logic        w;
        a = BASE + 32'h200 + 32'(mir) * 32'h200 + 32'(ch) * 16 + 32'(word) * 4;
        cycle(1'b0, 1'b1, a, '0, 1'b0, '0, rpush(), rcin(), 1'b0);
        for (int f = 0; f < TIMEOUT; f++) begin
            check("fetch_req", 32'(ch_req), 32'd1);
            check("fetch_sel", 32'(ch_sel), 32'(ch));
            check("fetch_word", 32'(ch_word), 32'(word));
            check("fetch_rvalid", 32'(rvalid), 32'd0);
            if (f == delay) begin
                cycle(1'b0, 1'b0, a, '0, 1'b1, data, rpush(), rcin(), 1'b0);
                check("ack_rdata", rdata, data);
                break;
            end else if (f == TIMEOUT - 1) begin
                cycle(1'b0, 1'b0, a, '0, 1'b0, '0, rpush(), rcin(), 1'b1);
                check("tmo_rdata", rdata, ERR_WORD);
                break;
            end else begin
                pick_wr(wa, wd);
                w = ($urandom % 4) == 0;
                cycle(w, !w, wa, wd, 1'b0, '0, rpush(), rcin(), 1'b0);
            end
        end
        check("resp_rvalid", 32'(rvalid), 32'd1);
        check("resp_req", 32'(ch_req), 32'd0);
        cycle(1'b0, 1'b1, a, '0, 1'($urandom), $urandom, rpush(), rcin(), 1'b0);
        check("chan_end_rvalid", 32'(rvalid), 32'd0);
        check("chan_end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(ch_req), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_run", 32'(run), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Count with pushes
        wr(32'h104, 32'd5);
        wr(32'h100, 32'd1);
        repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b0);
        csr_read(BASE + 32'h104, 1'b0, '0);

        // Limit auto-stop with done interrupt
        wr(32'h110, 32'd10);
        wr(32'h104, 32'd8);
        wr(32'h114, 32'd1);
        repeat (2) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        csr_read(BASE + 32'h104, 1'b0, '0);
        csr_read(BASE + 32'h100, 1'b0, '0);
        csr_read(BASE + 32'h10C, 1'b0, '0);
        wr(32'h10C, 32'h3);

        // Sticky CSEEN: set wins over same-cycle clear
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 32'h8, 1'b0);
        cycle(1'b1, 1'b0, BASE + 32'h108, 32'h8, 1'b0, '0, 1'b0, 32'h8, 1'b0);
        csr_read(BASE + 32'h108, 1'b0, '0);
        wr(32'h108, 32'hffff_ffff);
        csr_read(BASE + 32'h108, 1'b0, '0);

        // Channel fetch at BASE+0x4A4, then a timeout
        chan_read(10, 1, 1, 4, 32'h1234);
        chan_read(3, 2, 0, 1000, 32'h0);
        csr_read(BASE + 32'h10C, 1'b0, '0);

        // Saturation and unmapped offsets
        wr(32'h110, 32'd0);
        wr(32'h100, 32'd1);
        wr(32'h104, 32'hffff_ffff);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b0);
        csr_read(BASE + 32'h104, 1'b0, '0);
        wr(32'h11C, 32'h55);
        csr_read(BASE + 32'h11C, 1'b0, '0);
        csr_read(BASE + 32'h000, 1'b0, '0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom % 4)
                0: begin
                    pick_wr(a, d);
                    cycle(1'b1, 1'b0, a, d, 1'($urandom), $urandom, rpush(), rcin(), 1'b0);
                end
                1: begin
                    pick_wr(a, d);
                    csr_read(a, ($urandom % 3) == 0, d);
                end
                2: chan_read(int'($urandom % 32), int'($urandom % 4), int'($urandom % 3),
                             int'($urandom % 20), $urandom);
                default: cycle(1'b0, 1'b0, '0, '0, 1'($urandom), $urandom, rpush(), rcin(), 1'b0);
            endcase
        end

        // Reset in the middle of a fetch
        cycle(1'b0, 1'b1, BASE + 32'h2A0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        check("pre_rst_req", 32'(ch_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_req", 32'(ch_req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_run", 32'(run), 32'd0);
        model_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        wr(32'h110, 32'h77);
        csr_read(BASE + 32'h110, 1'b0, '0);
        csr_read(BASE + 32'h104, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
